// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single main-memory port between the instruction fetch path
// (I-port, read-only) and the L1 data cache controller (D-port, read/write).
// One request is latched at a time, the memory is driven for MEM_LATENCY
// cycles, the read data is captured and the winning port gets a one-cycle
// ack pulse. Sequence: IDLE -> BUSY (MEM_LATENCY cycles) -> RESP -> IDLE, so
// a request sampled in cycle 0 is acked in cycle MEM_LATENCY+1.
//
// Parameters
//   ADDR_WIDTH      address width
//   DATA_WIDTH      data width
//   MEM_LATENCY     cycles mem_* are held before mem_dout is valid (1..15)
//   DPORT_PRIORITY  1: D-port wins ties; 0: round-robin between ports
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   synchronous reset, active-low
//   i_req/i_addr      in   I-port request (held until i_ack) and word address
//   i_rdata/i_ack     out  I-port read data and completion pulse
//   d_req             in   D-port request, held until d_ack
//   d_write_en        in   D-port write
//   d_type_control    in   access size: 00 byte, 01 half, 10 word
//   d_addr/d_din      in   D-port address and write data
//   d_sign_ext        in   D-port read sign extension
//   d_rdata/d_ack     out  D-port read data and completion pulse
//   mem_write_en      out  memory write strobe (first BUSY cycle only)
//   mem_type_control  out  memory access size
//   mem_addr/mem_din  out  memory address and write data
//   mem_sign_ext      out  memory sign extension
//   mem_dout          in   memory read data
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_LATENCY    = 2,
    parameter bit DPORT_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,

    input  logic                  d_req,
    input  logic                  d_write_en,
    input  logic [1:0]            d_type_control,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_din,
    input  logic                  d_sign_ext,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,

    output logic                  mem_write_en,
    output logic [1:0]            mem_type_control,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_sign_ext,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int         CNT_W     = 4;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    port_t                 port_q;        // port owning the current transaction
    port_t                 last_grant_q;  // port served by the last completed transaction
    port_t                 grant_port_d;

    logic                  mem_write_en_q;
    logic [1:0]            mem_type_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic                  mem_sign_ext_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  i_ack_q;
    logic                  d_ack_q;

    // Arbitration: D wins when alone, when it has fixed priority, or when the
    // round-robin pointer says the I-port was served last.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_port_d = PORT_I;
        if (d_req && (!i_req || DPORT_PRIORITY || last_grant_q == PORT_I)) begin
            grant_port_d = PORT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the datapath registers (latched request, read data) are
            // reset too, because every output must read 0 straight after a
            // reset, including one that aborts a transaction in flight.
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            port_q         <= PORT_I;
            last_grant_q   <= PORT_I;
            mem_write_en_q <= 1'b0;
            mem_type_q     <= '0;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            mem_sign_ext_q <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first, later assignments in the same
            // block override them; this makes the strobe and acks one-cycle
            // pulses without extra clear logic in every branch.
            mem_write_en_q <= 1'b0;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        port_q  <= grant_port_d;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                        state_q <= ST_BUSY;
                        if (grant_port_d == PORT_D) begin
                            mem_write_en_q <= d_write_en;
                            mem_type_q     <= d_type_control;
                            mem_addr_q     <= d_addr;
                            mem_din_q      <= d_din;
                            mem_sign_ext_q <= d_sign_ext;
                        end else begin
                            // Instruction fetch is always a plain word read.
                            mem_type_q     <= TYPE_WORD;
                            mem_addr_q     <= i_addr;
                            mem_din_q      <= '0;
                            mem_sign_ext_q <= 1'b0;
                        end
                    end
                end

                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        // Writes capture mem_dout too; the value is simply unused.
                        if (port_q == PORT_D) begin
                            d_rdata_q <= mem_dout;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_dout;
                            i_ack_q   <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_RESP: begin
                    last_grant_q <= port_q;
                    state_q      <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_write_en     = mem_write_en_q;
    assign mem_type_control = mem_type_q;
    assign mem_addr         = mem_addr_q;
    assign mem_din          = mem_din_q;
    assign mem_sign_ext     = mem_sign_ext_q;
    assign i_rdata          = i_rdata_q;
    assign d_rdata          = d_rdata_q;
    assign i_ack            = i_ack_q;
    assign d_ack            = d_ack_q;

endmodule
